// File: rtl/hazard_fwd_ctrl.sv
// Hazard and operand-source controller for the five-stage integer pipeline.
// Tracks EX/MEM destinations, registers forwarding/mov-source selects, stalls on load-use.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              id_mov_imm,
  input  logic              ex_flush,
  input  logic              mem_busy,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel,
  output logic              ex_movsrc_sel,
  output logic [CNT_W-1:0]  lu_stall_cnt
);

  logic              ex_v, ex_we, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_v, mem_we;
  logic [REG_AW-1:0] mem_rd;

  logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic       lu;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    hit_ex_a  = id_valid & id_rs1_used & ex_v  & ex_we  & (ex_rd  == id_rs1);
    hit_ex_b  = id_valid & id_rs2_used & ex_v  & ex_we  & (ex_rd  == id_rs2);
    hit_mem_a = id_valid & id_rs1_used & mem_v & mem_we & (mem_rd == id_rs1);
    hit_mem_b = id_valid & id_rs2_used & mem_v & mem_we & (mem_rd == id_rs2);
    lu        = id_valid & ex_ld & (hit_ex_a | hit_ex_b);
    id_stall  = mem_busy | (lu & ~ex_flush);

    // The younger producer in EX always wins over the one in MEM.
    fwd_a = 2'b00;
    if (hit_ex_a)       fwd_a = 2'b01;
    else if (hit_mem_a) fwd_a = 2'b10;
    fwd_b = 2'b00;
    if (hit_ex_b)       fwd_b = 2'b01;
    else if (hit_mem_b) fwd_b = 2'b10;
  end

  assign ex_valid = ex_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v          <= 1'b0;
      ex_we         <= 1'b0;
      ex_ld         <= 1'b0;
      ex_rd         <= '0;
      mem_v         <= 1'b0;
      mem_we        <= 1'b0;
      mem_rd        <= '0;
      ex_fwd_a_sel  <= 2'b00;
      ex_fwd_b_sel  <= 2'b00;
      ex_movsrc_sel <= 1'b0;
      lu_stall_cnt  <= '0;
    end else if (!mem_busy) begin
      mem_v  <= ex_v;
      mem_we <= ex_we;
      mem_rd <= ex_rd;
      if (ex_flush || lu) begin
        ex_v          <= 1'b0;
        ex_we         <= 1'b0;
        ex_ld         <= 1'b0;
        ex_fwd_a_sel  <= 2'b00;
        ex_fwd_b_sel  <= 2'b00;
        ex_movsrc_sel <= 1'b0;
        if (!ex_flush && lu_stall_cnt != {CNT_W{1'b1}})
          lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      end else begin
        ex_v          <= id_valid;
        ex_we         <= id_valid & id_rd_we;
        ex_ld         <= id_valid & id_is_load;
        ex_rd         <= id_rd;
        ex_fwd_a_sel  <= fwd_a;
        ex_fwd_b_sel  <= fwd_b;
        ex_movsrc_sel <= id_valid & id_mov_imm;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: expected EX outputs are queued when an
// ID instruction is driven and popped after the following rising edge.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_mov_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_flush, mem_busy;
  logic       id_stall, ex_valid, ex_movsrc_sel;
  logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel;
  logic [3:0] lu_stall_cnt;

  typedef struct {
    string      tag;
    logic       v;
    logic [1:0] a;
    logic [1:0] b;
    logic       mov;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .id_mov_imm(id_mov_imm), .ex_flush(ex_flush), .mem_busy(mem_busy),
    .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
    .ex_movsrc_sel(ex_movsrc_sel), .lu_stall_cnt(lu_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t e;
    n_asserts++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("[TB] FAIL scoreboard_empty: got size %0d required >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_asserts++;
      assert (ex_valid === e.v) else begin
        n_fail++;
        $error("[TB] FAIL %s ex_valid: got %b required %b", e.tag, ex_valid, e.v);
      end
      n_asserts++;
      assert (ex_fwd_a_sel === e.a) else begin
        n_fail++;
        $error("[TB] FAIL %s fwd_a: got %b required %b", e.tag, ex_fwd_a_sel, e.a);
      end
      n_asserts++;
      assert (ex_fwd_b_sel === e.b) else begin
        n_fail++;
        $error("[TB] FAIL %s fwd_b: got %b required %b", e.tag, ex_fwd_b_sel, e.b);
      end
      n_asserts++;
      assert (ex_movsrc_sel === e.mov) else begin
        n_fail++;
        $error("[TB] FAIL %s movsrc: got %b required %b", e.tag, ex_movsrc_sel, e.mov);
      end
      n_asserts++;
      assert (lu_stall_cnt === e.cnt) else begin
        n_fail++;
        $error("[TB] FAIL %s lu_cnt: got %0d required %0d", e.tag, lu_stall_cnt, e.cnt);
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus(
    input string tag,
    input logic v, input logic [4:0] rs1, input logic u1,
    input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd, input logic we, input logic ld, input logic mi,
    input logic flush, input logic busy,
    input logic x_stall, input logic x_v, input logic [1:0] x_a,
    input logic [1:0] x_b, input logic x_mov, input logic [3:0] x_cnt);
    exp_t e;
    id_valid = v;  id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2;  id_rs2_used = u2;
    id_rd = rd;    id_rd_we = we; id_is_load = ld; id_mov_imm = mi;
    ex_flush = flush; mem_busy = busy;
    #1;
    n_asserts++;
    assert (id_stall === x_stall) else begin
      n_fail++;
      $error("[TB] FAIL %s id_stall: got %b required %b", tag, id_stall, x_stall);
    end
    e.tag = tag; e.v = x_v; e.a = x_a; e.b = x_b; e.mov = x_mov; e.cnt = x_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    n_asserts++;
    assert ({ex_valid, ex_fwd_a_sel, ex_fwd_b_sel, ex_movsrc_sel, lu_stall_cnt, id_stall} === 11'd0)
    else begin
      n_fail++;
      $error("[TB] FAIL %s reset_outputs: got %b%b%b%b%b%b required all zero", tag,
             ex_valid, ex_fwd_a_sel, ex_fwd_b_sel, ex_movsrc_sel, lu_stall_cnt, id_stall);
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_is_load = 0; id_mov_imm = 0;
    ex_flush = 0; mem_busy = 0;
    #2;
    checkReset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // tag               v rs1 u rs2 u rd we ld mi fl bz   stl v a     b     mv cnt
    applyStimulus("alu_p",   1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 0);
    applyStimulus("alu_c",   1, 3, 1, 0, 0,10, 1, 0, 0, 0, 0,  0, 1, 2'b01, 2'b00, 0, 0);
    applyStimulus("d2_p5",   1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 0);
    applyStimulus("d2_p7",   1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 0);
    applyStimulus("d2_c",    1, 5, 1, 7, 1,11, 1, 0, 0, 0, 0,  0, 1, 2'b10, 2'b01, 0, 0);
    applyStimulus("pr_p1",   1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 0);
    applyStimulus("pr_p2",   1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 0);
    applyStimulus("pr_c",    1, 5, 1, 5, 0,12, 1, 0, 0, 0, 0,  0, 1, 2'b01, 2'b00, 0, 0);
    applyStimulus("lw",      1,12, 1, 0, 0, 4, 1, 1, 0, 0, 0,  0, 1, 2'b01, 2'b00, 0, 0);
    applyStimulus("lu_stall",1,12, 1, 4, 1,13, 1, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0, 1);
    applyStimulus("lu_retry",1,12, 1, 4, 1,13, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b10, 0, 1);
    applyStimulus("lw2",     1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 1);
    applyStimulus("flush_lu",1, 6, 1, 0, 0,14, 1, 0, 0, 1, 0,  0, 0, 2'b00, 2'b00, 0, 1);
    applyStimulus("mov_imm", 1, 6, 1, 0, 0, 8, 1, 0, 1, 0, 0,  0, 1, 2'b10, 2'b00, 1, 1);
    applyStimulus("busy1",   1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 1,  1, 1, 2'b10, 2'b00, 1, 1);
    applyStimulus("busy2",   1, 8, 1, 0, 0, 9, 1, 0, 0, 1, 1,  1, 1, 2'b10, 2'b00, 1, 1);
    applyStimulus("busy3",   1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 1,  1, 1, 2'b10, 2'b00, 1, 1);
    applyStimulus("post_bsy",1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0,  0, 1, 2'b01, 2'b00, 0, 1);
    applyStimulus("invalid", 0, 9, 1, 9, 1,15, 1, 0, 1, 0, 0,  0, 0, 2'b00, 2'b00, 0, 1);
    applyStimulus("pre_r20", 1, 0, 0, 0, 0,20, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 1);
    applyStimulus("pre_r21", 1, 0, 0, 0, 0,21, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 1);

    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0;
    rst_n = 1'b0;
    #1;
    checkReset("mid_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst",1,21, 1,20, 1,22, 1, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 0, 0);

    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus("sat_lw",   1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 4'(cnt));
      cnt = (cnt < 15) ? cnt + 1 : 15;
      applyStimulus("sat_use",  1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 4'(cnt));
      applyStimulus("sat_retry",1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 4'(cnt));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
